// File: rtl/mem_bus_initiator.sv
// Single-outstanding initiator for the core memory bus: core request -> valid/ready bus request -> response pulse.
// Optional watchdog abort (with DRAIN of one late response) enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_initiator #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic        core_rsp_valid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  output logic        bus_rsp_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rsp_err
);

`ifdef MEM_BUS_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, REQ, RSP, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
`endif

  state_t      r_state, w_next;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        r_rsp_valid, r_err;
  logic        w_accept, w_rsp_hs, w_abort;

  assign w_accept = (r_state == IDLE) && core_valid;
  assign w_rsp_hs = (r_state == RSP) && bus_rsp_valid;

`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       w_expired;

  // Counter saturates at zero so a request handshaken exactly at expiry
  // still gets one response cycle before the abort fires from RSP.
  assign w_expired = (r_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= 8'd0;
    else if (w_accept)
      r_cnt <= TIMEOUT;
    else if (((r_state == REQ) || (r_state == RSP)) && !w_expired)
      r_cnt <= r_cnt - 8'd1;
  end
`endif

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      IDLE: if (core_valid) w_next = REQ;
      REQ: begin
        if (bus_req_ready) w_next = RSP;
`ifdef MEM_BUS_TIMEOUT_EN
        else if (w_expired) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end
`endif
      end
      RSP: begin
        if (bus_rsp_valid) w_next = IDLE;
`ifdef MEM_BUS_TIMEOUT_EN
        else if (w_expired) begin
          w_next  = DRAIN;
          w_abort = 1'b1;
        end
`endif
      end
`ifdef MEM_BUS_TIMEOUT_EN
      DRAIN: if (bus_rsp_valid) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= w_rsp_hs || w_abort;
      if (w_accept) begin
        r_we    <= core_we;
        r_addr  <= core_addr;
        r_wdata <= core_wdata;
        r_wstrb <= core_we ? core_wstrb : 4'd0;
      end
      if (w_rsp_hs) begin
        r_rdata <= r_we ? 32'd0 : bus_rdata;
        r_err   <= bus_rsp_err;
      end else if (w_abort) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b1;
      end
    end
  end

  assign core_ready     = (r_state == IDLE);
  assign bus_req_valid  = (r_state == REQ);
`ifdef MEM_BUS_TIMEOUT_EN
  assign bus_rsp_ready  = (r_state == RSP) || (r_state == DRAIN);
`else
  assign bus_rsp_ready  = (r_state == RSP);
`endif
  assign core_rsp_valid = r_rsp_valid;
  assign core_rdata     = r_rdata;
  assign core_err       = r_err;
  assign bus_we         = r_we;
  assign bus_addr       = r_addr;
  assign bus_wdata      = r_wdata;
  assign bus_wstrb      = r_wstrb;

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Core-side initiator for the CPU's simple memory bus, used by IFU/LSU to issue one outstanding read or write.
- Captures a core request, drives a valid/ready request channel, then waits for the response from the latency-modelled memory responder.
- Returns a one-cycle response pulse with read data and an error flag. Optional watchdog aborts requests to a responder that never answers.

Parameters:
- TIMEOUT, 8'd255: cycles allowed from bus request issue to response before abort; used only with the optional feature; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- core_valid  in  1  core request valid.
- core_ready  out  1  initiator can accept a request; high only in IDLE.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  32  byte address.
- core_wdata  in  32  write data.
- core_wstrb  in  4  byte enables; ignored for reads.
- core_rsp_valid  out  1  one-cycle response pulse.
- core_rdata  out  32  read data; 0 for writes and aborts.
- core_err  out  1  error flag; qualified by core_rsp_valid.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  responder accepts request.
- bus_we, bus_addr[31:0], bus_wdata[31:0], bus_wstrb[3:0]  out  registered copies of the captured request; stable while bus_req_valid=1.
- bus_rsp_valid  in  1  responder response valid.
- bus_rsp_ready  out  1  initiator accepts response.
- bus_rdata  in  32  response data.
- bus_rsp_err  in  1  response error.

Behaviour:
- States: IDLE, REQ, RSP, DRAIN. DRAIN exists only with the optional feature.
- Reset values: state=IDLE; all outputs 0 except core_ready=1; captured request registers 0. Reset mid-operation returns to IDLE immediately and discards any outstanding transaction. Any later bus response is not the initiator's concern.
- IDLE: core_ready=1 (combinational from state). On core_valid=1, capture we/addr/wdata/wstrb (wstrb forced to 0 for reads) and go to REQ.
- REQ: bus_req_valid=1 with held fields. On bus_req_ready=1, go to RSP.
- RSP: bus_rsp_ready=1. On bus_rsp_valid=1:
  - register core_rdata = we ? 0 : bus_rdata and core_err = bus_rsp_err;
  - pulse core_rsp_valid for exactly 1 cycle (the cycle after the handshake);
  - go to IDLE.
- Minimum latency, with ready and response both zero-wait: accept at cycle N, bus_req_valid at N+1, response handshake at N+2, core_rsp_valid at N+3.
- Back-to-back: core_ready=1 during the core_rsp_valid cycle, so a new request may be accepted in that same cycle.
- core_rdata and core_err hold their value until the next response; core_rsp_valid=0 otherwise.
- Only one outstanding transaction. core_valid is ignored outside IDLE.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Enabled:
  - An 8-bit down-counter loads TIMEOUT on entering REQ and decrements every cycle in REQ/RSP.
  - At count==0 with no handshake that cycle, the request aborts: core_rsp_valid=1, core_err=1, core_rdata=0 on the next cycle.
  - Abort from REQ drops bus_req_valid and goes to IDLE.
  - Abort from RSP goes to DRAIN. DRAIN holds bus_rsp_ready=1 and core_ready=0, absorbs exactly one late bus_rsp_valid without reporting it, then returns to IDLE.
  - If a handshake and count==0 occur in the same cycle, the handshake wins and no abort occurs.
- Disabled: no counter and no DRAIN state; the initiator waits indefinitely, and core_err reflects only bus_rsp_err.

Test Plan:
- Read, zero-wait: core read addr=0x80000010, ready/response immediate with bus_rdata=0xDEADBEEF -> core_rsp_valid at accept+3, core_rdata=0xDEADBEEF, core_err=0.
- Write with stalls: write addr=0x100, wdata=0x12345678, wstrb=4'b0011, bus_req_ready delayed 4 cycles, response 3 cycles later -> bus fields stable throughout, single pulse, core_rdata=0.
- Error response: read with bus_rsp_err=1 -> core_err=1 with core_rsp_valid; the next read with err=0 clears it.
- Back-to-back: a second core_valid in the core_rsp_valid cycle -> accepted, bus_req_valid the next cycle, no idle bubble.
- Reset mid-op: assert rst while in RSP -> next cycle core_ready=1, bus_req_valid=0, bus_rsp_ready=0, core_rsp_valid stays 0.
- MEM_BUS_TIMEOUT_EN, TIMEOUT=5: responder never answers -> abort with core_err=1; a late response is absorbed in DRAIN, and the next request completes normally. A response arriving exactly at count 0 is reported with core_err=0.
